async_fifo_wptr_full: RTL and testbench

Write-domain pointer and flag controller for the dual-clock FIFO. It sits in the wclk_i domain and consumes the Gray read pointer already synchronized into that domain. It produces the binary RAM write address, the RAM write enable, and the Gray write pointer that is handed to the write-to-read synchronizer. It also produces full, almost-full, fill-level and sticky overflow status.

---
 rtl/async_fifo_pkg.sv | 22 ++
 rtl/async_fifo_wptr_full_if.sv | 25 ++
 rtl/async_fifo_wptr_full.sv | 65 ++++++
 tb/tb_async_fifo_wptr_full.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: default geometry and Gray/binary conversion.
package async_fifo_pkg;

  localparam int unsigned ASYNC_FIFO_ADDRSIZE = 4;

  // The arguments are zero-extended, so callers of any width up to 32 bits
  // cast in, call the function, and cast the result back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int unsigned i = 1; i < 32; i++) begin
      b[31-i] = b[32-i] ^ g[31-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_full_if.sv
// Write-side bus of the FIFO pointer/flag controller: producer handshake, synced read pointer, status.
interface async_fifo_wptr_full_if #(
  parameter int unsigned ADDRSIZE = 4
);
  logic                winc_i;
  logic [ADDRSIZE:0]   rptr_sync_i;
  logic                wovf_clr_i;
  logic [ADDRSIZE-1:0] waddr_o;
  logic                wen_o;
  logic [ADDRSIZE:0]   wptr_g_o;
  logic                wfull_o;
  logic                walmost_full_o;
  logic [ADDRSIZE:0]   wlevel_o;
  logic                woverflow_o;

  modport master (
    output winc_i, rptr_sync_i, wovf_clr_i,
    input  waddr_o, wen_o, wptr_g_o, wfull_o, walmost_full_o, wlevel_o, woverflow_o
  );

  modport slave (
    input  winc_i, rptr_sync_i, wovf_clr_i,
    output waddr_o, wen_o, wptr_g_o, wfull_o, walmost_full_o, wlevel_o, woverflow_o
  );
endinterface

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and flag controller of the dual-clock FIFO.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = ASYNC_FIFO_ADDRSIZE,
  parameter int unsigned AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
  input logic                   wclk_i,
  input logic                   wrst_n_i,
  async_fifo_wptr_full_if.slave bus
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] wbin, wbin_next;
  logic [ADDRSIZE:0] wgray, wgray_next;
  logic [ADDRSIZE:0] rbin, rptr_full_cmp;
  logic [ADDRSIZE:0] level, level_next;
  logic              full, full_next;
  logic              afull, afull_next;
  logic              ovf, ovf_next;
  logic              wen;

  assign wen = bus.winc_i & ~full;

  always_comb begin
    wbin_next  = wbin + PW'(wen);
    wgray_next = PW'(bin2gray(32'(wbin_next)));
    rbin       = PW'(gray2bin(32'(bus.rptr_sync_i)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    rptr_full_cmp = {~bus.rptr_sync_i[ADDRSIZE:ADDRSIZE-1], bus.rptr_sync_i[ADDRSIZE-2:0]};
    full_next  = (wgray_next == rptr_full_cmp);
    level_next = wbin_next - rbin;
    afull_next = (32'(level_next) >= AFULL_THRESH);
    // Set dominates a simultaneous clear.
    ovf_next   = (bus.winc_i & full) | (ovf & ~bus.wovf_clr_i);
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      wbin  <= '0;
      wgray <= '0;
      full  <= 1'b0;
      afull <= 1'b0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      full  <= full_next;
      afull <= afull_next;
      level <= level_next;
      ovf   <= ovf_next;
    end
  end

  assign bus.waddr_o        = wbin[ADDRSIZE-1:0];
  assign bus.wen_o          = wen;
  assign bus.wptr_g_o       = wgray;
  assign bus.wfull_o        = full;
  assign bus.walmost_full_o = afull;
  assign bus.wlevel_o       = level;
  assign bus.woverflow_o    = ovf;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Scoreboard bench for async_fifo_wptr_full with ADDRSIZE=4, AFULL_THRESH=12.
module tb_async_fifo_wptr_full;

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] wptr_g;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
    logic       accepted;
    logic [4:0] old_g;
  } exp_t;

  logic wclk;
  logic wrst_n;
  int unsigned total;
  int unsigned bad;
  exp_t sb_q[$];

  // Reference state: binary pointers and occupancy as plain arithmetic.
  logic [4:0] m_wbin;
  logic       m_full;
  logic       m_ovf;

  async_fifo_wptr_full_if #(.ADDRSIZE(4)) bus();

  async_fifo_wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk_i   (wclk),
    .wrst_n_i (wrst_n),
    .bus      (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of stimulus (rd_bin is the binary read pointer; the bench
  // encodes it to Gray), check wen_o combinationally, then score the edge.
  task automatic step(input logic winc, input logic [4:0] rd_bin, input logic clr);
    exp_t       e;
    exp_t       g;
    logic       acc;
    logic [4:0] lvl;
    @(negedge wclk);
    bus.winc_i      = winc;
    bus.rptr_sync_i = rd_bin ^ (rd_bin >> 1);
    bus.wovf_clr_i  = clr;
    #1;
    acc = winc & ~m_full;
    chk("wen", 32'(bus.wen_o), 32'(acc));
    e.old_g    = bus.wptr_g_o;
    e.accepted = acc;
    m_ovf      = (winc & m_full) | (m_ovf & ~clr);
    m_wbin     = m_wbin + 5'(acc);
    lvl        = m_wbin - rd_bin;
    m_full     = (lvl == 5'd16);
    e.waddr    = m_wbin[3:0];
    e.wptr_g   = m_wbin ^ (m_wbin >> 1);
    e.full     = m_full;
    e.afull    = (lvl >= 5'd12);
    e.level    = lvl;
    e.ovf      = m_ovf;
    sb_q.push_back(e);
    @(posedge wclk);
    #1;
    g = sb_q.pop_front();
    chk("waddr",  32'(bus.waddr_o),        32'(g.waddr));
    chk("wptr_g", 32'(bus.wptr_g_o),       32'(g.wptr_g));
    chk("wfull",  32'(bus.wfull_o),        32'(g.full));
    chk("afull",  32'(bus.walmost_full_o), 32'(g.afull));
    chk("wlevel", 32'(bus.wlevel_o),       32'(g.level));
    chk("wovf",   32'(bus.woverflow_o),    32'(g.ovf));
    if (g.accepted)
      chk("gray_hamming", $countones(g.old_g ^ bus.wptr_g_o), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waddr"},  32'(bus.waddr_o),        0);
    chk({tag, "_wptr_g"}, 32'(bus.wptr_g_o),       0);
    chk({tag, "_wfull"},  32'(bus.wfull_o),        0);
    chk({tag, "_afull"},  32'(bus.walmost_full_o), 0);
    chk({tag, "_wlevel"}, 32'(bus.wlevel_o),       0);
    chk({tag, "_wovf"},   32'(bus.woverflow_o),    0);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    #3;
    wrst_n          = 1'b0;
    bus.winc_i      = 1'b0;
    bus.wovf_clr_i  = 1'b0;
    bus.rptr_sync_i = '0;
    #1;
    chk_all_zero("rst_async");
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    wrst_n = 1'b0;
    bus.winc_i      = 1'b0;
    bus.rptr_sync_i = '0;
    bus.wovf_clr_i  = 1'b0;
    model_reset();
    #12;
    chk_all_zero("rst_init");
    @(negedge wclk);
    wrst_n = 1'b1;

    // Traffic, then asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 1'b0);
    chk("pre_rst_level", 32'(bus.wlevel_o), 3);
    do_reset();

    // Fill from empty with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 5'd0, 1'b0);
      chk("fill_afull_edge", 32'(bus.walmost_full_o), (i >= 11) ? 1 : 0);
    end
    chk("fill_full",   32'(bus.wfull_o),  1);
    chk("fill_level",  32'(bus.wlevel_o), 16);
    chk("fill_gray",   32'(bus.wptr_g_o), 32'h18);
    chk("fill_waddr",  32'(bus.waddr_o),  0);

    // Overflow set, clear, and set-wins-over-clear.
    step(1'b1, 5'd0, 1'b0);
    chk("ovf_set",     32'(bus.woverflow_o), 1);
    chk("ovf_ptr_hold", 32'(bus.wptr_g_o),   32'h18);
    step(1'b0, 5'd0, 1'b1);
    chk("ovf_clr",     32'(bus.woverflow_o), 0);
    step(1'b1, 5'd0, 1'b0);
    step(1'b1, 5'd0, 1'b1);
    chk("ovf_set_wins", 32'(bus.woverflow_o), 1);

    // Release: one read becomes visible through the synced pointer.
    step(1'b0, 5'd1, 1'b1);
    chk("rel_full",  32'(bus.wfull_o),  0);
    chk("rel_level", 32'(bus.wlevel_o), 15);
    chk("rel_waddr", 32'(bus.waddr_o),  0);
    step(1'b1, 5'd1, 1'b0);
    chk("rel_after_write_full", 32'(bus.wfull_o), 1);

    // Wrap: read pointer trails the new write pointer by two for 32 writes.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 5'(m_wbin - 5'd1), 1'b0);
      chk("wrap_level", 32'(bus.wlevel_o), 2);
      chk("wrap_nofull", 32'(bus.wfull_o), 0);
      if (i == 15) chk("wrap_waddr_15", 32'(bus.waddr_o), 0);
    end
    chk("wrap_gray_home", 32'(bus.wptr_g_o), 0);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
